fetch_unit: RTL and testbench

Instruction fetch stage for the single-clock MIPS32 core. It owns the program counter, drives both read addresses of the dual-read-port instruction memory, and captures up to two instructions per cycle into a small queue. Decode drains the queue one instruction per cycle over a valid/ready handshake. A redirect input from the branch/jump logic flushes the queue and reloads the PC.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 68 ++++++
 tb/tb_fetch_unit.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared MIPS32 fetch definitions: widths, reset PC and the {pc, instr} queue entry layout.
package fetch_unit_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 6;
    localparam int QDEPTH_DEF = 4;
    localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Byte address to instruction-memory word index; the top bits drop so the index wraps.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [DATA_WIDTH-1:0] byte_addr);
        return byte_addr[ADDR_WIDTH+1:2];
    endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: dual-port imem reads, redirect from branch logic, and the decode handshake.
interface fetch_if;
    import fetch_unit_pkg::*;

    logic [ADDR_WIDTH-1:0] imem_a1;
    logic [ADDR_WIDTH-1:0] imem_a2;
    logic [DATA_WIDTH-1:0] imem_rd1;
    logic [DATA_WIDTH-1:0] imem_rd2;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  out_ready;

    modport master (
        output imem_a1, imem_a2, out_valid, out_instr, out_pc,
        input  imem_rd1, imem_rd2, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_a1, imem_a2, out_valid, out_instr, out_pc,
        output imem_rd1, imem_rd2, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-write / one-read circular queue of fetch entries with a flush that clears pointers and count.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int  QDEPTH = QDEPTH_DEF,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    push_n,
    input  fetch_entry_t  wr_entry1,
    input  fetch_entry_t  wr_entry2,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem_q [QDEPTH];
    fetch_entry_t  mem_d [QDEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = {PW{1'b0}};
            rptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            case (push_n)
                2'd1: mem_d[wptr_q] = wr_entry1;
                2'd2: begin
                    mem_d[wptr_q]          = wr_entry1;
                    mem_d[wptr_q + PW'(1)] = wr_entry2;
                end
                default: mem_d[wptr_q] = mem_q[wptr_q];
            endcase
            wptr_d  = wptr_q + PW'(push_n);
            rptr_d  = rptr_q + PW'(pop);
            count_d = count_q + CW'(push_n) - CW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, dual-slot imem fetch into fetch_queue, redirect has top priority.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         count_s;
    logic [CW-1:0]         free_s;
    logic [1:0]            push_n_s;
    logic                  pop_s;
    fetch_entry_t          entry1_s;
    fetch_entry_t          entry2_s;
    fetch_entry_t          head_s;

    // Push count uses registered occupancy only so out_ready never reaches the imem address.
    always_comb begin
        free_s = CW'(QDEPTH) - count_s;
        if (bus.redirect_valid) begin
            push_n_s = 2'd0;
            pc_d     = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end else begin
            if (free_s >= CW'(2)) begin
                push_n_s = 2'd2;
            end else begin
                push_n_s = free_s[1:0];
            end
            pc_d = pc_q + DATA_WIDTH'({push_n_s, 2'b00});
        end
    end

    // Program counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign entry1_s = '{pc: pc_q,          instr: bus.imem_rd1};
    assign entry2_s = '{pc: pc_q + 32'd4,  instr: bus.imem_rd2};
    assign pop_s    = bus.out_valid && bus.out_ready && !bus.redirect_valid;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push_n    (push_n_s),
        .wr_entry1 (entry1_s),
        .wr_entry2 (entry2_s),
        .pop       (pop_s),
        .flush     (bus.redirect_valid),
        .head      (head_s),
        .count     (count_s)
    );

    assign bus.imem_a1   = word_index(pc_q);
    assign bus.imem_a2   = bus.imem_a1 + ADDR_WIDTH'(1);
    assign bus.out_valid = (count_s != CW'(0));
    assign bus.out_instr = head_s.instr;
    assign bus.out_pc    = head_s.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an imem model returning 0x1000_0000 + word index.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_if bus ();

    assign bus.imem_rd1 = 32'h1000_0000 + {26'd0, bus.imem_a1};
    assign bus.imem_rd2 = 32'h1000_0000 + {26'd0, bus.imem_a2};

    fetch_unit #(.QDEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return 32'h1000_0000 + {26'd0, pc[7:2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_pc"}, bus.out_pc, pc);
        check({tag, "_instr"}, bus.out_instr, exp_instr(pc));
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        rst                = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        #1;
        rst = 1'b1;
        #2;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_pc",    bus.out_pc,    32'd0);
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_a1",    {26'd0, bus.imem_a1}, 32'd0);
        check("rst_a2",    {26'd0, bus.imem_a2}, 32'd1);
        step();
        rst = 1'b0;

        // Streaming with decode always ready: one instruction per cycle, no gaps.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_head("stream", 32'(4 * i));
        end

        // Backpressure: queue fills to 4 and the fetch address freezes at word 4.
        do_reset();
        step();
        step();
        check("bp_a1_full", {26'd0, bus.imem_a1}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("bp_a1_hold", {26'd0, bus.imem_a1}, 32'd4);
        check("bp_a2_hold", {26'd0, bus.imem_a2}, 32'd5);
        check_head("bp_head", 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            check_head("resume", 32'(4 * i));
        end

        // Redirect to 0x22 while full and ready: queue empties, target head two cycles later.
        bus.out_ready = 1'b0;
        step();
        step();
        check("full_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0022;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_empty", {31'd0, bus.out_valid}, 32'd0);
        check("redir_a1",    {26'd0, bus.imem_a1}, 32'd8);
        step();
        check("redir_pc",    bus.out_pc,    32'h0000_0020);
        check("redir_instr", bus.out_instr, 32'h1000_0008);

        // Redirect to 0xFC: second slot wraps to imem word 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_00FC;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap_empty", {31'd0, bus.out_valid}, 32'd0);
        check("wrap_a1",    {26'd0, bus.imem_a1}, 32'd63);
        check("wrap_a2",    {26'd0, bus.imem_a2}, 32'd0);
        step();
        check("wrap_pc0",    bus.out_pc,    32'h0000_00FC);
        check("wrap_instr0", bus.out_instr, 32'h1000_003F);
        step();
        check("wrap_pc1",    bus.out_pc,    32'h0000_0100);
        check("wrap_instr1", bus.out_instr, 32'h1000_0000);

        // Count 3 with decode stalled: exactly one slot captured, pc advances 4.
        check("c3_a1", {26'd0, bus.imem_a1}, 32'd3);
        bus.out_ready = 1'b0;
        step();
        check("c3_a1_adv", {26'd0, bus.imem_a1}, 32'd4);
        check_head("c3_head", 32'h0000_0100);
        step();
        check("c3_a1_hold", {26'd0, bus.imem_a1}, 32'd4);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check_head("c3_drain", 32'(32'h100 + 4 * i));
        end

        // Asynchronous reset between edges clears outputs at once.
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_pc",    bus.out_pc, 32'd0);
        check("arst_a1",    {26'd0, bus.imem_a1}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_head("restart", 32'(4 * i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
